btb_next_pc_unit: RTL and testbench

- Parametrised successor to the decode-stage next-PC calculator.
- Adds a direct-mapped branch target buffer (BTB) with saturating direction counters, used for IF-stage next-PC prediction.
- Resolves branch/jump targets in ID, detects mispredictions, redirects fetch and trains the BTB.
- Sits between the PC register/IF stage and the IF/ID register outputs.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/sat_counter.sv | 19 +
 rtl/btb_next_pc_unit.sv | 90 +++++++++
 tb/tb_btb_next_pc_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants and the BTB entry layout shared by the fetch/decode logic.
package cpu_pkg;
   localparam logic [5:0] OPCODE_J   = 6'h02;
   localparam logic [5:0] OPCODE_JAL = 6'h03;
   localparam logic [5:0] OPCODE_BEQ = 6'h04;
   localparam logic [5:0] OPCODE_BNE = 6'h05;
   localparam int CTR_MAX_W = 8;
   // tag holds pc >> (IDX_W+2), right-aligned, so one layout serves every ENTRIES value
   typedef struct packed {
      logic                 valid;
      logic [31:0]          tag;
      logic [31:0]          target;
      logic [CTR_MAX_W-1:0] ctr;
   } btb_entry_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up/down counter with synchronous clear and parallel load.
module sat_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   input  logic         dec,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count
);
   always_ff @(posedge clk) begin
      if (clear) count <= '0;
      else if (load) count <= load_val;
      else if (inc && count != '1) count <= count + 1'b1;
      else if (dec && count != '0) count <= count - 1'b1;
   end
endmodule

// File: rtl/btb_next_pc_unit.sv
// btb_next_pc_unit: direct-mapped BTB next-PC prediction in IF, branch/jump resolution
// and BTB training in ID, with a saturating mispredict counter.
module btb_next_pc_unit
   import cpu_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      if_pc,
   output logic [31:0]      if_pred_pc,
   output logic             if_pred_taken,
   input  logic             id_valid,
   input  logic [31:0]      id_pc_next,
   input  logic [31:0]      id_instr,
   input  logic             id_is_branch,
   input  logic             id_branch_cond,
   input  logic             id_is_jump,
   input  logic [31:0]      id_pred_pc,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] mispredict_cnt
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TS    = IDX_W + 2;
   logic [ENTRIES-1:0]            valid;
   logic [31:0]                   tag_mem [ENTRIES];
   logic [31:0]                   tgt_mem [ENTRIES];
   logic [ENTRIES-1:0][CTR_W-1:0] ctr;
   logic [IDX_W-1:0]              fi, ti;
   logic [31:0]                   id_pc, ttag, btgt, jtgt;
   logic                          taken, train, thit;
   logic [CTR_W-1:0]              init_ctr;
   btb_entry_t                    rd;
   always_comb begin
      fi            = if_pc[IDX_W+1:2];
      rd.valid      = valid[fi];
      rd.tag        = tag_mem[fi];
      rd.target     = tgt_mem[fi];
      rd.ctr        = CTR_MAX_W'(ctr[fi]);
      if_pred_taken = rd.valid && rd.tag == (if_pc >> TS) && rd.ctr >= CTR_MAX_W'(1 << (CTR_W - 1));
      if_pred_pc    = if_pred_taken ? rd.target : if_pc + 32'd4;
      btgt          = id_pc_next + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
      jtgt          = {id_pc_next[31:28], id_instr[25:0], 2'b00};
      taken         = id_is_jump || (id_is_branch && id_branch_cond);
      redirect_pc   = id_is_jump ? jtgt : (id_is_branch && id_branch_cond) ? btgt : id_pc_next;
      redirect      = !reset && id_valid && id_pred_pc != redirect_pc;
      id_pc         = id_pc_next - 32'd4;
      ti            = id_pc[IDX_W+1:2];
      ttag          = id_pc >> TS;
      train         = !reset && id_valid && (id_is_branch || id_is_jump);
      thit          = valid[ti] && tag_mem[ti] == ttag;
      init_ctr      = id_is_jump ? '1 : CTR_W'(1) << (CTR_W - 1);
   end
   always_ff @(posedge clk) begin
      if (reset) valid <= '0;
      else if (train && taken) valid[ti] <= 1'b1;
   end
   // tags and targets need no reset: valid gates every use of them
   always_ff @(posedge clk) begin
      if (train && taken) begin
         tag_mem[ti] <= ttag;
         tgt_mem[ti] <= redirect_pc;
      end
   end
   for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
      logic wr;
      assign wr = train && ti == IDX_W'(i);
      sat_counter #(.W(CTR_W)) u_ctr (
         .clk      (clk),
         .clear    (reset),
         .inc      (wr && thit && taken),
         .dec      (wr && thit && !taken),
         .load     (wr && !thit && taken),
         .load_val (init_ctr),
         .count    (ctr[i])
      );
   end
   sat_counter #(.W(CNT_W)) u_miss (
      .clk      (clk),
      .clear    (reset),
      .inc      (redirect),
      .dec      (1'b0),
      .load     (1'b0),
      .load_val ('0),
      .count    (mispredict_cnt)
   );
endmodule

// File: tb/tb_btb_next_pc_unit.sv
// tb_btb_next_pc_unit: scoreboard bench for btb_next_pc_unit; expectations are queued
// when stimulus is driven and compared on the following falling edge.
module tb_btb_next_pc_unit;
   import cpu_pkg::*;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] if_pc, if_pred_pc, id_pc_next, id_instr, id_pred_pc, redirect_pc;
   logic        if_pred_taken, id_valid, id_is_branch, id_branch_cond, id_is_jump, redirect;
   logic [15:0] mispredict_cnt;
   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_cnt = '0;
   bit          will_redir;
   string       tq[$];
   int          sq[$];
   logic [31:0] eq[$];

   btb_next_pc_unit dut (
      .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_pc(if_pred_pc),
      .if_pred_taken(if_pred_taken), .id_valid(id_valid), .id_pc_next(id_pc_next),
      .id_instr(id_instr), .id_is_branch(id_is_branch), .id_branch_cond(id_branch_cond),
      .id_is_jump(id_is_jump), .id_pred_pc(id_pred_pc), .redirect(redirect),
      .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] obs(input int s);
      return s == 0 ? {31'd0, if_pred_taken} : s == 1 ? if_pred_pc : s == 2 ? {31'd0, redirect} :
             s == 3 ? redirect_pc : {16'd0, mispredict_cnt};
   endfunction

   task automatic expect_val(input string tag, input int s, input logic [31:0] v);
      tq.push_back(tag);
      sq.push_back(s);
      eq.push_back(v);
   endtask

   task automatic cyc();
      expect_val("cnt", 4, {16'd0, exp_cnt});
      @(negedge clk);
      while (sq.size() > 0) check(tq.pop_front(), obs(sq.pop_front()), eq.pop_front());
      if (will_redir && !reset && exp_cnt != 16'hFFFF) exp_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [31:0] pc, input logic tk, input logic [31:0] pred);
      if_pc = pc;
      expect_val("taken", 0, {31'd0, tk});
      expect_val("pred_pc", 1, pred);
   endtask

   task automatic idle();
      id_valid = 0; id_is_branch = 0; id_is_jump = 0; id_branch_cond = 0;
      id_pc_next = 32'h0; id_pred_pc = 32'h0; id_instr = 32'h0; will_redir = 0;
   endtask

   task automatic resolve(input logic redir, input logic [31:0] rpc);
      will_redir = redir;
      expect_val("redirect", 2, {31'd0, redir});
      if (redir) expect_val("redirect_pc", 3, rpc);
   endtask

   task automatic branch(input logic [31:0] pc, input logic [15:0] imm, input logic cond,
                         input logic [31:0] pred, input logic redir, input logic [31:0] rpc);
      id_valid = 1; id_is_branch = 1; id_is_jump = 0; id_branch_cond = cond;
      id_pc_next = pc + 32'd4; id_pred_pc = pred; id_instr = {OPCODE_BEQ, 5'd1, 5'd2, imm};
      resolve(redir, rpc);
   endtask

   task automatic jump(input logic [31:0] pc, input logic [25:0] t26, input logic both,
                       input logic [31:0] pred, input logic [31:0] rpc);
      id_valid = 1; id_is_jump = 1; id_is_branch = both; id_branch_cond = both;
      id_pc_next = pc + 32'd4; id_pred_pc = pred; id_instr = {OPCODE_J, t26};
      resolve(1'b1, rpc);
   endtask

   initial begin
      reset = 1;
      idle();
      if_pc = 32'h0040_0000;
      @(posedge clk);
      #1;
      branch(32'h0040_0010, 16'h3, 1, 32'h0, 0, 32'h0);
      cyc();
      reset = 0;
      idle();
      lookup(32'h0040_0000, 0, 32'h0040_0004);
      cyc();
      branch(32'h0040_0010, 16'h3, 1, 32'h0040_0014, 1, 32'h0040_0020);
      cyc();
      idle();
      lookup(32'h0040_0010, 1, 32'h0040_0020);
      cyc();
      branch(32'h0040_0010, 16'h3, 0, 32'h0040_0020, 1, 32'h0040_0014);
      lookup(32'h0040_0010, 1, 32'h0040_0020);
      cyc();
      branch(32'h0040_0010, 16'h3, 0, 32'h0040_0014, 0, 32'h0);
      lookup(32'h0040_0010, 0, 32'h0040_0014);
      cyc();
      branch(32'h0040_0010, 16'h3, 0, 32'h0040_0014, 0, 32'h0);
      lookup(32'h0040_0010, 0, 32'h0040_0014);
      cyc();
      idle();
      lookup(32'h0040_0010, 0, 32'h0040_0014);
      cyc();
      branch(32'h0040_0010, 16'h3, 1, 32'h0040_0014, 1, 32'h0040_0020);
      cyc();
      branch(32'h0040_0010, 16'h3, 1, 32'h0040_0014, 1, 32'h0040_0020);
      lookup(32'h0040_0010, 0, 32'h0040_0014);
      cyc();
      idle();
      lookup(32'h0040_0010, 1, 32'h0040_0020);
      cyc();
      jump(32'h1000_0000, 26'h000_0100, 0, 32'h1000_0004, 32'h1000_0400);
      cyc();
      idle();
      lookup(32'h1000_0000, 1, 32'h1000_0400);
      cyc();
      jump(32'h2000_0000, 26'h000_0003, 1, 32'h2000_0004, 32'h2000_000C);
      cyc();
      branch(32'h0040_0000, 16'h3, 1, 32'h0040_0004, 1, 32'h0040_0010);
      cyc();
      idle();
      lookup(32'h0040_0000, 1, 32'h0040_0010);
      cyc();
      branch(32'h0040_0040, 16'h3, 1, 32'h0040_0044, 1, 32'h0040_0050);
      cyc();
      idle();
      lookup(32'h0040_0040, 1, 32'h0040_0050);
      cyc();
      lookup(32'h0040_0000, 0, 32'h0040_0004);
      cyc();
      idle();
      id_valid = 1; id_pc_next = 32'h0060_0004; id_pred_pc = 32'h0; will_redir = 1;
      for (int i = 0; i < 65535; i++) cyc();
      expect_val("redirect_sat", 2, 32'h1);
      cyc();
      check("cnt_sat", {16'd0, mispredict_cnt}, 32'h0000_FFFF);
      idle();
      lookup(32'h0040_0040, 1, 32'h0040_0050);
      cyc();
      reset = 1;
      branch(32'h0050_0000, 16'h3, 1, 32'h0, 0, 32'h0);
      cyc();
      reset = 0;
      exp_cnt = '0;
      idle();
      lookup(32'h0040_0040, 0, 32'h0040_0044);
      cyc();
      lookup(32'h1000_0000, 0, 32'h1000_0004);
      cyc();
      lookup(32'h0050_0000, 0, 32'h0050_0004);
      cyc();
      branch(32'h0040_0040, 16'h3, 1, 32'h0, 0, 32'h0);
      id_valid = 0;
      cyc();
      idle();
      lookup(32'h0040_0040, 0, 32'h0040_0044);
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
